// File: rtl/ifu_bpu_pkg.sv
// Purpose : shared encodings for the fetch-stage branch predictor (counters, FSM, index width).
// Latency : n/a (types and pure functions only).
// Backpr. : n/a. Build option IFU_BPU_BHT_EN selects the dynamic BHT in ifu_bpu.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

package ifu_bpu_pkg;

    // 2-bit saturating direction counter encodings
    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // BHT controller states: INIT sweeps the array, RUN serves updates
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bpu_state_e;

    // Value every counter holds once the init sweep has passed over it
    localparam logic [1:0] CNT_INIT_VAL = CNT_WNT;

    // Index width for a BHT of the given (power-of-two) depth
    function automatic int bht_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Saturating counter step: +1 on taken, -1 on not-taken, clamped at ST/SNT
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ifu_bpu_bht.sv
// Purpose : branch history table of 2-bit counters with init sweep, saturating update and write-first bypass.
// Latency : lookup is combinational (registered by the parent); update is written on the next rising edge.
// Backpr. : none; updates are always accepted in RUN and silently dropped while the sweep runs.
module ifu_bpu_bht
    import ifu_bpu_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int PC_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] i_lkp_pc,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    output logic [1:0]      o_lkp_cnt,
    output logic            o_init_busy
);

    localparam int               IDX_W    = bht_idx_w(BHT_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BHT_DEPTH - 1);

    bpu_state_e       r_state;
    bpu_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [IDX_W-1:0] w_sweep_idx_nxt;

    // Counter array; deliberately not reset, the sweep initialises it
    logic [1:0]       r_cnt [BHT_DEPTH];

    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_upd_cur;
    logic [1:0]       w_upd_nxt;
    logic             w_upd_en;
    logic             w_busy;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [1:0]       w_wr_dat;
    logic             w_unused_pc;

    // Word-aligned PCs: bits [1:0] never select an entry
    assign w_lkp_idx   = i_lkp_pc[IDX_W+1:2];
    assign w_upd_idx   = i_upd_pc[IDX_W+1:2];
    assign w_unused_pc = ^{i_lkp_pc[PC_W-1:IDX_W+2], i_lkp_pc[1:0],
                           i_upd_pc[PC_W-1:IDX_W+2], i_upd_pc[1:0]};

    // Read-modify-write value for the entry being trained this cycle
    assign w_upd_cur = r_cnt[w_upd_idx];
    assign w_upd_nxt = cnt_next(w_upd_cur, i_upd_taken);

    // FSM state register and sweep index; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_idx_nxt;
        end
    end

    // Next-state logic and single write-port arbitration (sweep owns the port in INIT)
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        w_busy          = 1'b0;
        w_upd_en        = 1'b0;
        w_wr_en         = 1'b0;
        w_wr_idx        = w_upd_idx;
        w_wr_dat        = w_upd_nxt;
        case (r_state)
            ST_INIT: begin
                w_busy          = 1'b1;
                w_wr_en         = 1'b1;
                w_wr_idx        = r_sweep_idx;
                w_wr_dat        = CNT_INIT_VAL;
                w_sweep_idx_nxt = r_sweep_idx + IDX_W'(1);
                if (r_sweep_idx == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_upd_en = i_upd_valid;
                w_wr_en  = i_upd_valid;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Counter array write; suppressed while reset is held so a restart sweeps cleanly
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            r_cnt[w_wr_idx] <= w_wr_dat;
        end
    end

    // Write-first bypass: a same-cycle update to the looked-up entry is visible immediately
    always_comb begin
        o_lkp_cnt = r_cnt[w_lkp_idx];
        if (w_upd_en && (w_upd_idx == w_lkp_idx)) begin
            o_lkp_cnt = w_upd_nxt;
        end
    end

    assign o_init_busy = w_busy;

endmodule

// File: rtl/ifu_bpu.sv
// Purpose : fetch-stage branch predictor: direction (BHT or static BTFN), target adder, prediction register.
// Latency : 1 cycle from accepted lookup to o_pred_*; flush clears valid next cycle.
// Backpr. : i_if_stall holds the prediction register; i_pipe_flush dominates stall. Option IFU_BPU_BHT_EN.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module ifu_bpu
    import ifu_bpu_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int PC_W      = `PC_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_if_valid,
    input  logic [PC_W-1:0] i_if_pc,
    input  logic            i_if_bjp,
    input  logic [PC_W-1:0] i_if_imm,
    input  logic            i_if_stall,
    input  logic            i_pipe_flush,
    input  logic            i_upd_valid,
    input  logic [PC_W-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    output logic            o_pred_valid,
    output logic            o_predict_flag,
    output logic [PC_W-1:0] o_predict_pc,
    output logic            o_init_busy
);

    logic            w_static_taken;
    logic            w_taken;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_tgt_pc;
    logic [PC_W-1:0] w_next_pc;

    logic            r_pred_valid;
    logic            r_predict_flag;
    logic [PC_W-1:0] r_predict_pc;

    // Backward-taken / forward-not-taken: a negative offset means a loop back-edge
    assign w_static_taken = i_if_bjp & i_if_imm[PC_W-1];

`ifdef IFU_BPU_BHT_EN
    logic [1:0] w_lkp_cnt;
    logic       w_init_busy;

    ifu_bpu_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .PC_W      (PC_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lkp_pc    (i_if_pc),
        .i_upd_valid (i_upd_valid),
        .i_upd_pc    (i_upd_pc),
        .i_upd_taken (i_upd_taken),
        .o_lkp_cnt   (w_lkp_cnt),
        .o_init_busy (w_init_busy)
    );

    // Counters are meaningless until swept, so fall back to the static rule meanwhile
    assign w_taken     = w_init_busy ? w_static_taken : (i_if_bjp & w_lkp_cnt[1]);
    assign o_init_busy = w_init_busy;
`else
    logic w_unused_upd;

    // No history kept: resolver feedback has nowhere to go
    assign w_unused_upd = ^{i_upd_valid, i_upd_pc, i_upd_taken};
    assign w_taken      = w_static_taken;
    assign o_init_busy  = 1'b0;
`endif

    // Both candidate next-fetch PCs wrap modulo 2^PC_W
    assign w_seq_pc  = i_if_pc + PC_W'(4);
    assign w_tgt_pc  = i_if_pc + i_if_imm;
    assign w_next_pc = w_taken ? w_tgt_pc : w_seq_pc;

    // Prediction register: flush kills, stall holds, otherwise capture this cycle's lookup
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pred_valid   <= 1'b0;
            r_predict_flag <= 1'b0;
            r_predict_pc   <= '0;
        end else if (i_pipe_flush) begin
            r_pred_valid   <= 1'b0;
        end else if (!i_if_stall) begin
            r_pred_valid   <= i_if_valid;
            if (i_if_valid) begin
                r_predict_flag <= w_taken;
                r_predict_pc   <= w_next_pc;
            end
        end
    end

    assign o_pred_valid   = r_pred_valid;
    assign o_predict_flag = r_predict_flag;
    assign o_predict_pc   = r_predict_pc;

endmodule

// File: tb/tb_ifu_bpu.sv
// Purpose : directed self-checking bench for ifu_bpu (static build and IFU_BPU_BHT_EN build).
// Latency : checks o_pred_* one cycle after each lookup, sampled 1 time unit after the edge.
// Backpr. : exercises stall hold, flush dominance and update-under-stall/flush.
module tb_ifu_bpu;

`ifdef IFU_BPU_BHT_EN
    localparam bit BHT = 1'b1;
`else
    localparam bit BHT = 1'b0;
`endif
    localparam logic [31:0] NEG8 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_if_valid;
    logic [31:0] i_if_pc;
    logic        i_if_bjp;
    logic [31:0] i_if_imm;
    logic        i_if_stall;
    logic        i_pipe_flush;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic        o_pred_valid;
    logic        o_predict_flag;
    logic [31:0] o_predict_pc;
    logic        o_init_busy;

    int checks = 0;
    int errors = 0;
    int busy_n;

    ifu_bpu #(
        .BHT_DEPTH (64),
        .PC_W      (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_if_valid     (i_if_valid),
        .i_if_pc        (i_if_pc),
        .i_if_bjp       (i_if_bjp),
        .i_if_imm       (i_if_imm),
        .i_if_stall     (i_if_stall),
        .i_pipe_flush   (i_pipe_flush),
        .i_upd_valid    (i_upd_valid),
        .i_upd_pc       (i_upd_pc),
        .i_upd_taken    (i_upd_taken),
        .o_pred_valid   (o_pred_valid),
        .o_predict_flag (o_predict_flag),
        .o_predict_pc   (o_predict_pc),
        .o_init_busy    (o_init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic v, input logic f, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, o_pred_valid}, {31'd0, v});
        chk({tag, ".flag"}, {31'd0, o_predict_flag}, {31'd0, f});
        chk({tag, ".pc"}, o_predict_pc, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_if_valid   = 1'b0;
        i_if_bjp     = 1'b0;
        i_if_stall   = 1'b0;
        i_pipe_flush = 1'b0;
        i_upd_valid  = 1'b0;
        i_upd_taken  = 1'b0;
    endtask

    task automatic lkp(input logic [31:0] pc, input logic bjp, input logic [31:0] imm);
        i_if_valid = 1'b1;
        i_if_pc    = pc;
        i_if_bjp   = bjp;
        i_if_imm   = imm;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        i_upd_valid = 1'b1;
        i_upd_pc    = pc;
        i_upd_taken = tk;
    endtask

    // Counts busy cycles starting with the current one, bounded so a stuck sweep still ends
    task automatic count_busy(output int n);
        n = 0;
        while (o_init_busy && n < 200) begin
            n++;
            tick();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        i_if_pc  = '0;
        i_if_imm = '0;
        i_upd_pc = '0;
        idle();
        tick();
        tick();
        chk_pred("reset", 1'b0, 1'b0, 32'h0);
        chk("reset.busy", {31'd0, o_init_busy}, {31'd0, BHT});

        // Release reset with a backward branch lookup during the sweep
        rst_n = 1'b1;
        lkp(32'h200, 1'b1, NEG8);
        tick();
        idle();
        chk_pred("sweep_lookup", 1'b1, 1'b1, 32'h1F8);
        count_busy(busy_n);
        chk("init_busy_cycles", busy_n + (BHT ? 1 : 0), BHT ? 64 : 0);

        // Fresh counter is weakly not-taken
        lkp(32'h100, 1'b1, 32'h20);
        tick();
        idle();
        chk_pred("fresh_lookup", 1'b1, 1'b0, 32'h104);

        // Two taken updates flip the prediction
        upd(32'h100, 1'b1);
        tick();
        tick();
        idle();
        lkp(32'h100, 1'b1, 32'h20);
        tick();
        idle();
        chk_pred("trained_taken", 1'b1, BHT, BHT ? 32'h120 : 32'h104);

        // Third taken saturates at 11 instead of wrapping to 00
        upd(32'h100, 1'b1);
        tick();
        idle();
        lkp(32'h100, 1'b1, 32'h20);
        tick();
        idle();
        chk_pred("sat_high", 1'b1, BHT, BHT ? 32'h120 : 32'h104);

        // Four not-taken then one taken: 01 -> 00 (sat) -> 01
        upd(32'h40, 1'b0);
        repeat (4) tick();
        upd(32'h40, 1'b1);
        tick();
        idle();
        lkp(32'h40, 1'b1, 32'h10);
        tick();
        idle();
        chk_pred("sat_low", 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b1);
        tick();
        idle();
        lkp(32'h40, 1'b1, 32'h10);
        tick();
        idle();
        chk_pred("sat_low_step", 1'b1, BHT, BHT ? 32'h50 : 32'h44);

        // Same-cycle update and lookup see the post-update counter
        upd(32'h80, 1'b1);
        lkp(32'h80, 1'b1, 32'h40);
        tick();
        idle();
        chk_pred("bypass", 1'b1, BHT, BHT ? 32'hC0 : 32'h84);

        // Flush beats stall and a valid lookup; update still lands
        lkp(32'h10, 1'b0, 32'h0);
        i_if_stall   = 1'b1;
        i_pipe_flush = 1'b1;
        upd(32'hC0, 1'b1);
        tick();
        idle();
        chk("flush_stall.valid", {31'd0, o_pred_valid}, 32'd0);
        lkp(32'hC0, 1'b1, 32'h8);
        tick();
        idle();
        chk_pred("upd_under_flush", 1'b1, BHT, BHT ? 32'hC8 : 32'hC4);

        // Stall holds the prediction register
        lkp(32'h300, 1'b0, 32'h0);
        tick();
        chk_pred("pre_stall", 1'b1, 1'b0, 32'h304);
        lkp(32'h400, 1'b1, NEG8);
        i_if_stall = 1'b1;
        tick();
        chk_pred("stall_hold", 1'b1, 1'b0, 32'h304);
        i_if_valid = 1'b0;
        tick();
        chk("stall_novalid.valid", {31'd0, o_pred_valid}, 32'd1);
        idle();
        tick();
        chk("bubble.valid", {31'd0, o_pred_valid}, 32'd0);

        // Flush alone kills a valid lookup
        lkp(32'h500, 1'b0, 32'h0);
        i_pipe_flush = 1'b1;
        tick();
        idle();
        chk("flush_only.valid", {31'd0, o_pred_valid}, 32'd0);

        // Sequential PC wraps; non-branch never taken; backward branch by mode
        lkp(32'hFFFF_FFFC, 1'b0, 32'h0);
        tick();
        chk_pred("wrap_seq", 1'b1, 1'b0, 32'h0);
        lkp(32'h4, 1'b1, NEG8);
        tick();
        chk_pred("backward", 1'b1, !BHT, BHT ? 32'h8 : 32'hFFFF_FFFC);
        lkp(32'h10, 1'b0, NEG8);
        tick();
        idle();
        chk_pred("nonbranch_neg", 1'b1, 1'b0, 32'h14);

        // Reset in RUN, then again at sweep index 30: sweep restarts from 0
        rst_n = 1'b0;
        tick();
        chk_pred("reset_run", 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        repeat (30) tick();
        chk("mid_sweep.busy", {31'd0, o_init_busy}, {31'd0, BHT});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        count_busy(busy_n);
        chk("restart_busy_cycles", busy_n, BHT ? 64 : 0);

        // Re-swept counter is back to weakly not-taken
        lkp(32'h100, 1'b1, 32'h20);
        tick();
        idle();
        chk_pred("reswept", 1'b1, 1'b0, 32'h104);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
